// File: rtl/anim_sequencer.sv
// Animation sequencer: picks the bitmap frame index and horizontal scroll offset once per video frame.
// Optional build macro ANIM_PINGPONG_EN makes frame_idx bounce between 0 and NUM_FRAMES-1 instead of wrapping.
module anim_sequencer #(
    parameter int NUM_FRAMES   = 2,
    parameter int DEFAULT_HOLD = 16,
    parameter int SCROLL_BITS  = 10,
    parameter int SCROLL_STEP  = 2,
    localparam int FRAME_BITS  = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   frame_tick,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [1:0]             cmd_op,
    input  logic [7:0]             cmd_arg,
    output logic [FRAME_BITS-1:0]  frame_idx,
    output logic [SCROLL_BITS-1:0] scroll_x,
    output logic                   playing
);

    typedef enum logic [1:0] {
        ST_PLAYING   = 2'd0,
        ST_PAUSED    = 2'd1,
        ST_STEP_PEND = 2'd2
    } state_t;

    localparam logic [1:0] OP_PLAY     = 2'd0;
    localparam logic [1:0] OP_PAUSE    = 2'd1;
    localparam logic [1:0] OP_STEP     = 2'd2;
    localparam logic [1:0] OP_SET_HOLD = 2'd3;

    localparam logic [FRAME_BITS-1:0] LAST_IDX = FRAME_BITS'(NUM_FRAMES - 1);

    state_t                 state_q, state_d;
    logic [FRAME_BITS-1:0]  idx_q, idx_d;
    logic [SCROLL_BITS-1:0] scroll_q, scroll_d;
    logic [7:0]             cnt_q, cnt_d;
    logic [7:0]             hold_q, hold_d;
    logic                   ready_q, playing_q;
    logic                   cmd_fire;
    logic                   adv_frame;
`ifdef ANIM_PINGPONG_EN
    logic                   dir_q, dir_d;   // 0 = counting up, 1 = counting down
`endif

    assign cmd_fire = cmd_valid && ready_q;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        scroll_d  = scroll_q;
        cnt_d     = cnt_q;
        hold_d    = hold_q;
        adv_frame = 1'b0;
`ifdef ANIM_PINGPONG_EN
        dir_d     = dir_q;
`endif

        // The tick sees the pre-command state; the command is layered on top below.
        if (frame_tick) begin
            case (state_q)
                ST_PLAYING: begin
                    scroll_d = scroll_q + SCROLL_BITS'(SCROLL_STEP);
                    if (cnt_q == hold_q - 8'd1) begin
                        cnt_d     = 8'd0;
                        adv_frame = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                ST_STEP_PEND: begin
                    scroll_d  = scroll_q + SCROLL_BITS'(SCROLL_STEP);
                    cnt_d     = 8'd0;
                    adv_frame = 1'b1;
                    state_d   = ST_PAUSED;
                end
                default: ;
            endcase
        end

        if (adv_frame) begin
`ifdef ANIM_PINGPONG_EN
            if (NUM_FRAMES > 1) begin
                if (!dir_q) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d = idx_q - 1'b1;
                        dir_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    if (idx_q == '0) begin
                        idx_d = idx_q + 1'b1;
                        dir_d = 1'b0;
                    end else begin
                        idx_d = idx_q - 1'b1;
                    end
                end
            end
`else
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
`endif
        end

        // STEP_PEND never accepts commands, so its tick transition cannot collide with one here.
        if (cmd_fire) begin
            case (cmd_op)
                OP_PLAY:  state_d = ST_PLAYING;
                OP_PAUSE: state_d = ST_PAUSED;
                OP_STEP: begin
                    if (state_q == ST_PAUSED) state_d = ST_STEP_PEND;
                end
                OP_SET_HOLD: begin
                    hold_d = (cmd_arg == 8'd0) ? 8'd1 : cmd_arg;
                    cnt_d  = 8'd0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_PLAYING;
            idx_q     <= '0;
            scroll_q  <= '0;
            cnt_q     <= 8'd0;
            hold_q    <= 8'(DEFAULT_HOLD);
            ready_q   <= 1'b1;
            playing_q <= 1'b1;
`ifdef ANIM_PINGPONG_EN
            dir_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            scroll_q  <= scroll_d;
            cnt_q     <= cnt_d;
            hold_q    <= hold_d;
            ready_q   <= (state_d != ST_STEP_PEND);
            playing_q <= (state_d == ST_PLAYING);
`ifdef ANIM_PINGPONG_EN
            dir_q     <= dir_d;
`endif
        end
    end

    assign frame_idx = idx_q;
    assign scroll_x  = scroll_q;
    assign cmd_ready = ready_q;
    assign playing   = playing_q;

endmodule

// File: tb/tb_anim_sequencer.sv
// Directed bench for anim_sequencer: default build, narrow scroll, one-frame and four-frame variants.
module tb_anim_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b0;
    logic       tick_a = 1'b0, vld_a = 1'b0;
    logic [1:0] op_a = 2'd0;
    logic [7:0] arg_a = 8'd0;
    logic       tick_bc = 1'b0, vld_bc = 1'b0;
    logic [1:0] op_bc = 2'd0;
    logic [7:0] arg_bc = 8'd0;

    logic [0:0] idx_a;
    logic [9:0] scr_a;
    logic       ply_a, rdy_a;
    logic [0:0] idx_b;
    logic [3:0] scr_b;
    logic       ply_b, rdy_b;
    logic [1:0] idx_c;
    logic [9:0] scr_c;
    logic       ply_c, rdy_c;

    anim_sequencer #(.NUM_FRAMES(2), .DEFAULT_HOLD(16), .SCROLL_BITS(10), .SCROLL_STEP(2)) u_a (
        .clk(clk), .rst_n(rst_n), .frame_tick(tick_a), .cmd_valid(vld_a), .cmd_ready(rdy_a),
        .cmd_op(op_a), .cmd_arg(arg_a), .frame_idx(idx_a), .scroll_x(scr_a), .playing(ply_a));

    anim_sequencer #(.NUM_FRAMES(1), .DEFAULT_HOLD(1), .SCROLL_BITS(4), .SCROLL_STEP(2)) u_b (
        .clk(clk), .rst_n(rst_n), .frame_tick(tick_bc), .cmd_valid(vld_bc), .cmd_ready(rdy_b),
        .cmd_op(op_bc), .cmd_arg(arg_bc), .frame_idx(idx_b), .scroll_x(scr_b), .playing(ply_b));

    anim_sequencer #(.NUM_FRAMES(4), .DEFAULT_HOLD(1), .SCROLL_BITS(10), .SCROLL_STEP(2)) u_c (
        .clk(clk), .rst_n(rst_n), .frame_tick(tick_bc), .cmd_valid(vld_bc), .cmd_ready(rdy_c),
        .cmd_op(op_bc), .cmd_arg(arg_bc), .frame_idx(idx_c), .scroll_x(scr_c), .playing(ply_c));

    typedef struct {
        logic       tick;
        logic       vld;
        logic [1:0] op;
        logic [7:0] arg;
        int         idx;
        int         scr;
        int         ply;
        int         rdy;
    } vec_t;

    vec_t vecs[28];
    int total = 0;
    int bad = 0;

    function automatic vec_t mk(input logic t, input logic v, input logic [1:0] o, input logic [7:0] a,
                                input int i, input int s, input int p, input int r);
        vec_t x;
        x.tick = t; x.vld = v; x.op = o; x.arg = a;
        x.idx = i; x.scr = s; x.ply = p; x.rdy = r;
        return x;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc_a(input logic t, input logic v, input logic [1:0] o, input logic [7:0] a);
        tick_a = t; vld_a = v; op_a = o; arg_a = a;
        @(posedge clk);
        #1;
        tick_a = 1'b0; vld_a = 1'b0; op_a = 2'd0; arg_a = 8'd0;
    endtask

    task automatic cyc_bc(input logic t);
        tick_bc = t;
        @(posedge clk);
        #1;
        tick_bc = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc_a(1'b0, 1'b0, 2'd0, 8'd0);
        cyc_a(1'b0, 1'b0, 2'd0, 8'd0);
        rst_n = 1'b1;
    endtask

    task automatic chk_a(input string name, input int i, input int s, input int p, input int r);
        chk({name, ".idx"}, int'(idx_a), i);
        chk({name, ".scroll"}, int'(scr_a), s);
        chk({name, ".playing"}, int'(ply_a), p);
        chk({name, ".ready"}, int'(rdy_a), r);
    endtask

`ifdef ANIM_PINGPONG_EN
    int seq_c[7] = '{1, 2, 3, 2, 1, 0, 1};
`else
    int seq_c[7] = '{1, 2, 3, 0, 1, 2, 3};
`endif

    initial begin
        // State entering the table: idx 0, scroll 80, hold_cnt 8, hold 16, playing.
        vecs[0]  = mk(1'b0, 1'b1, 2'd3, 8'd0, 0,  80, 1, 1);
        vecs[1]  = mk(1'b1, 1'b0, 2'd0, 8'd0, 1,  82, 1, 1);
        vecs[2]  = mk(1'b1, 1'b0, 2'd0, 8'd0, 0,  84, 1, 1);
        vecs[3]  = mk(1'b1, 1'b0, 2'd0, 8'd0, 1,  86, 1, 1);
        vecs[4]  = mk(1'b0, 1'b1, 2'd1, 8'd0, 1,  86, 0, 1);
        vecs[5]  = mk(1'b1, 1'b0, 2'd0, 8'd0, 1,  86, 0, 1);
        vecs[6]  = mk(1'b1, 1'b0, 2'd0, 8'd0, 1,  86, 0, 1);
        vecs[7]  = mk(1'b1, 1'b0, 2'd0, 8'd0, 1,  86, 0, 1);
        vecs[8]  = mk(1'b1, 1'b0, 2'd0, 8'd0, 1,  86, 0, 1);
        vecs[9]  = mk(1'b1, 1'b0, 2'd0, 8'd0, 1,  86, 0, 1);
        vecs[10] = mk(1'b0, 1'b1, 2'd2, 8'd0, 1,  86, 0, 0);
        vecs[11] = mk(1'b0, 1'b0, 2'd0, 8'd0, 1,  86, 0, 0);
        vecs[12] = mk(1'b0, 1'b1, 2'd0, 8'd0, 1,  86, 0, 0);
        vecs[13] = mk(1'b1, 1'b0, 2'd0, 8'd0, 0,  88, 0, 1);
        vecs[14] = mk(1'b1, 1'b0, 2'd0, 8'd0, 0,  88, 0, 1);
        vecs[15] = mk(1'b0, 1'b1, 2'd3, 8'd3, 0,  88, 0, 1);
        vecs[16] = mk(1'b1, 1'b1, 2'd0, 8'd0, 0,  88, 1, 1);
        vecs[17] = mk(1'b1, 1'b0, 2'd0, 8'd0, 0,  90, 1, 1);
        vecs[18] = mk(1'b1, 1'b0, 2'd0, 8'd0, 0,  92, 1, 1);
        vecs[19] = mk(1'b1, 1'b1, 2'd1, 8'd0, 1,  94, 0, 1);
        vecs[20] = mk(1'b1, 1'b0, 2'd0, 8'd0, 1,  94, 0, 1);
        vecs[21] = mk(1'b0, 1'b1, 2'd0, 8'd0, 1,  94, 1, 1);
        vecs[22] = mk(1'b0, 1'b1, 2'd2, 8'd0, 1,  94, 1, 1);
        vecs[23] = mk(1'b1, 1'b0, 2'd0, 8'd0, 1,  96, 1, 1);
        vecs[24] = mk(1'b1, 1'b1, 2'd3, 8'd3, 1,  98, 1, 1);
        vecs[25] = mk(1'b1, 1'b0, 2'd0, 8'd0, 1, 100, 1, 1);
        vecs[26] = mk(1'b1, 1'b0, 2'd0, 8'd0, 1, 102, 1, 1);
        vecs[27] = mk(1'b1, 1'b0, 2'd0, 8'd0, 0, 104, 1, 1);

        do_reset();
        chk_a("reset", 0, 0, 1, 1);

        for (int k = 1; k <= 40; k++) begin
            cyc_a(1'b1, 1'b0, 2'd0, 8'd0);
            chk($sformatf("play_tick%0d.idx", k), int'(idx_a), (k / 16) % 2);
            chk($sformatf("play_tick%0d.scroll", k), int'(scr_a), 2 * k);
        end

        for (int v = 0; v < 28; v++) begin
            cyc_a(vecs[v].tick, vecs[v].vld, vecs[v].op, vecs[v].arg);
            chk_a($sformatf("vec%0d", v), vecs[v].idx, vecs[v].scr, vecs[v].ply, vecs[v].rdy);
        end

        // Reset while a STEP is pending must drop it and restore the default hold.
        cyc_a(1'b0, 1'b1, 2'd1, 8'd0);
        cyc_a(1'b0, 1'b1, 2'd2, 8'd0);
        chk("step_pend.ready", int'(rdy_a), 0);
        do_reset();
        chk_a("rst_in_step", 0, 0, 1, 1);
        for (int k = 1; k <= 16; k++) begin
            cyc_a(1'b1, 1'b0, 2'd0, 8'd0);
        end
        chk("hold_default_after_rst.idx", int'(idx_a), 1);
        chk("hold_default_after_rst.scroll", int'(scr_a), 32);

        do_reset();
        for (int k = 1; k <= 8; k++) begin
            cyc_bc(1'b1);
            chk($sformatf("narrow_tick%0d.scroll", k), int'(scr_b), (2 * k) % 16);
            chk($sformatf("one_frame_tick%0d.idx", k), int'(idx_b), 0);
            if (k <= 4) chk($sformatf("four_pre_tick%0d.idx", k), int'(idx_c), seq_c[k-1]);
        end

        do_reset();
        chk("four_rst.idx", int'(idx_c), 0);
        for (int k = 1; k <= 7; k++) begin
            cyc_bc(1'b1);
            chk($sformatf("four_tick%0d.idx", k), int'(idx_c), seq_c[k-1]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
